// File: rtl/imm_pkg.sv
// imm_pkg: widths and state encoding shared by the immediate encoder
package imm_pkg;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 12;
  localparam int ROT_W  = 4;
  typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} imm_enc_state_t;
endpackage

// File: rtl/imm_rot_check.sv
// imm_rot_check: tests whether val rotated left by 2*rot leaves only the low byte set
module imm_rot_check
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0] val,
  input  logic [ROT_W-1:0]  rot,
  output logic              fits,
  output logic [7:0]        imm8
);
  logic [2*DATA_W-1:0] dbl;
  logic [DATA_W-1:0]   t;
  // rotate left via a doubled word so a zero rotation needs no special case
  always_comb begin
    dbl  = {val, val} << {rot, 1'b0};
    t    = dbl[2*DATA_W-1:DATA_W];
    fits = ~|t[DATA_W-1:8];
    imm8 = t[7:0];
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: iterative search for a 12-bit zero-extend or rotate immediate encoding
module imm_encoder
  import imm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] value,
  output logic              done,
  output logic              ok,
  output logic              form,
  output logic [IMM_W-1:0]  imm
);
  imm_enc_state_t    state, state_d;
  logic [DATA_W-1:0] val_q;
  logic [ROT_W-1:0]  rot_q;
  logic              fits;
  logic [7:0]        imm8;
  logic              res_en, ok_d, form_d;
  logic [IMM_W-1:0]  imm_d;
  imm_rot_check u_rot (
    .val  (val_q),
    .rot  (rot_q),
    .fits (fits),
    .imm8 (imm8)
  );
  assign in_ready = state == IDLE;
  assign done     = state == DONE;
  // next state and the result to latch when leaving CHECK or SEARCH for DONE
  always_comb begin
    state_d = state;
    res_en  = 1'b0;
    ok_d    = 1'b0;
    form_d  = 1'b0;
    imm_d   = '0;
    case (state)
      IDLE:   state_d = in_valid ? CHECK : IDLE;
      CHECK: begin
        res_en  = ~|val_q[DATA_W-1:IMM_W];
        ok_d    = res_en;
        imm_d   = res_en ? val_q[IMM_W-1:0] : '0;
        state_d = res_en ? DONE : SEARCH;
      end
      SEARCH: begin
        res_en  = fits | (&rot_q);
        ok_d    = fits;
        form_d  = fits;
        imm_d   = fits ? {rot_q, imm8} : '0;
        state_d = res_en ? DONE : SEARCH;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // result registers hold until the next search completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok   <= 1'b0;
      form <= 1'b0;
      imm  <= '0;
    end else if (res_en) begin
      ok   <= ok_d;
      form <= form_d;
      imm  <= imm_d;
    end
  end
  // input latch and rotation counter; rotation 0 is covered by CHECK so start at 1
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      val_q <= value;
      rot_q <= ROT_W'(1);
    end else if (state == SEARCH) begin
      rot_q <= rot_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder results and latencies
module tb_imm_encoder;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic [31:0] value = 0;
  logic        in_ready, done, ok, form;
  logic [11:0] imm;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  typedef struct packed {
    logic        ok;
    logic        form;
    logic [11:0] imm;
    int          lat;
    int          e;
  } exp_t;
  exp_t sb[$];

  imm_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .done     (done),
    .ok       (ok),
    .form     (form),
    .imm      (imm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] v, input int s);
    return (s % 32 == 0) ? v : ((v >> (s % 32)) | (v << (32 - s % 32)));
  endfunction

  // reference: value must lie inside the window ROR(0xFF, 2r)
  function automatic exp_t model(input logic [31:0] v);
    exp_t x;
    logic [31:0] t;
    x = '0;
    x.lat = 16;
    if (v[31:12] == 0) begin
      x.ok = 1;
      x.imm = v[11:0];
      x.lat = 1;
      return x;
    end
    for (int r = 1; r < 16; r++) begin
      if ((v & ~ror(32'hFF, 2 * r)) == 0) begin
        t = ror(v, 32 - 2 * r);
        x.ok = 1;
        x.form = 1;
        x.imm = {r[3:0], t[7:0]};
        x.lat = 1 + r;
        return x;
      end
    end
    return x;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 4095));
      1: begin
        b = 32'($urandom_range(0, 255));
        return ror(b, 2 * $urandom_range(0, 15));
      end
      2: return $urandom;
      default: begin
        b = 32'h0003_F000;
        return ($urandom_range(0, 1) == 0) ? b : 32'hFF00_0000;
      end
    endcase
  endfunction

  // scoreboard: push on acceptance, pop and compare on done
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) sb.delete();
    else begin
      if (done) begin
        if (sb.size() == 0) check("spurious_done", 1, 0);
        else begin
          x = sb.pop_front();
          check("ok", ok, x.ok);
          check("form", form, x.form);
          check("imm", imm, x.imm);
          check("latency", cyc - x.e, x.lat);
        end
      end
      if (in_valid && in_ready) begin
        x = model(value);
        x.e = cyc + 1;
        sb.push_back(x);
      end
    end
  end

  task automatic encode(input logic [31:0] v, input bit watch);
    int  n;
    bit  low;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1;
    value = v;
    @(posedge clk);
    #1;
    in_valid = 0;
    low = 1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (in_ready) low = 0;
      if (done) break;
      n++;
    end
    check("done_seen", 32'(n < 40), 1);
    if (watch) check("ready_low", 32'(low), 1);
    @(posedge clk);
    #1;
    check("ready_back", in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    check("rst_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_ok", ok, 0);
    check("rst_form", form, 0);
    check("rst_imm", imm, 0);
    encode(32'h0000_0ABC, 0);
    encode(32'hFF00_0000, 0);
    encode(32'h0003_F000, 0);
    encode(32'h0001_2345, 1);
    in_valid = 1;
    value = 32'h0001_2345;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 0;
    in_valid = 1;
    @(posedge clk);
    #1;
    rst_n = 1;
    in_valid = 0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_ok", ok, 0);
    check("mid_rst_imm", imm, 0);
    repeat (20) @(posedge clk);
    #1;
    encode(32'h0000_0000, 0);
    in_valid = 1;
    repeat (300) begin
      value = pick();
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    repeat (40) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
